pipelined_shifter: RTL and testbench

//   Parametrised, two-stage pipelined barrel shifter for the datapath shift unit.

---
 rtl/pipelined_shifter.sv | 130 +++++++++++++
 tb/tb_pipelined_shifter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// Two-stage pipelined barrel shifter (LSL/LSR/ASR/ROR/RRX) with an ARM-style carry-out
// and valid/ready handshakes on both sides.
module pipelined_shifter #(
    parameter int WIDTH  = 32,
    parameter int SHW    = $clog2(WIDTH),
    parameter bit RRX_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] ShIn,
    input  logic [SHW-1:0]   Shamt,
    input  logic [1:0]       Sh,
    input  logic             CarryIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ShOut,
    output logic             CarryOut
);

    localparam int         SPLIT = SHW / 2;
    localparam logic [1:0] LSL   = 2'b00;
    localparam logic [1:0] LSR   = 2'b01;
    localparam logic [1:0] ASR   = 2'b10;
    localparam logic [1:0] ROR   = 2'b11;
    localparam logic [SHW-1:0] ONE = SHW'(1);

    // One mux level: shift by a constant power of two in the selected mode.
    function automatic logic [WIDTH-1:0] shiftBy(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] mode,
                                                 input int k);
        logic [2*WIDTH-1:0] rot;
        logic [WIDTH-1:0]   r;
        rot = {d, d} >> k;
        case (mode)
            LSL:     r = d << k;
            LSR:     r = d >> k;
            ASR:     r = $signed(d) >>> k;
            default: r = rot[WIDTH-1:0];
        endcase
        return r;
    endfunction

    logic             s1ValidReg;
    logic [WIDTH-1:0] s1DataReg;
    logic [WIDTH-1:0] s1OrigReg;
    logic [SHW-1:0]   s1ShamtReg;
    logic [1:0]       s1ShReg;
    logic             s1CarryInReg;

    logic             s2ValidReg;
    logic [WIDTH-1:0] s2DataReg;
    logic             s2CarryReg;

    logic [WIDTH-1:0] s1DataNext;
    logic [WIDTH-1:0] s2DataNext;
    logic             s2CarryNext;
    logic [SHW-1:0]   carryIdx;
    logic             load1;
    logic             ld2;

    assign ld2     = s1ValidReg & (~s2ValidReg | OutReady);
    // Combinational path from OutReady to InReady lets a full pipe accept while it drains.
    assign InReady = ~s1ValidReg | ~s2ValidReg | OutReady;
    assign load1   = InValid & InReady;

    // Upper mux levels (MSB first) before the stage-1 register.
    always_comb begin
        s1DataNext = ShIn;
        for (int k = SHW - 1; k >= SPLIT; k--) begin
            if (Shamt[k]) begin
                s1DataNext = shiftBy(s1DataNext, Sh, 1 << k);
            end
        end
    end

    // Remaining levels plus carry select before the stage-2 register.
    always_comb begin
        s2DataNext = s1DataReg;
        for (int k = SPLIT - 1; k >= 0; k--) begin
            if (s1ShamtReg[k]) begin
                s2DataNext = shiftBy(s2DataNext, s1ShReg, 1 << k);
            end
        end
        // LSL carries out bit W-n, which is (-n) mod W since W is a power of two.
        carryIdx    = (s1ShReg == LSL) ? (~s1ShamtReg + ONE) : (s1ShamtReg - ONE);
        s2CarryNext = s1OrigReg[carryIdx];
        if (s1ShamtReg == '0) begin
            s2CarryNext = s1CarryInReg;
            if (RRX_EN && (s1ShReg == ROR)) begin
                s2DataNext  = {s1CarryInReg, s1OrigReg[WIDTH-1:1]};
                s2CarryNext = s1OrigReg[0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            s1ValidReg   <= 1'b0;
            s1DataReg    <= '0;
            s1OrigReg    <= '0;
            s1ShamtReg   <= '0;
            s1ShReg      <= '0;
            s1CarryInReg <= 1'b0;
            s2ValidReg   <= 1'b0;
            s2DataReg    <= '0;
            s2CarryReg   <= 1'b0;
        end else begin
            if (load1) begin
                s1DataReg    <= s1DataNext;
                s1OrigReg    <= ShIn;
                s1ShamtReg   <= Shamt;
                s1ShReg      <= Sh;
                s1CarryInReg <= CarryIn;
            end
            s1ValidReg <= load1 | (s1ValidReg & ~ld2);
            if (ld2) begin
                s2DataReg  <= s2DataNext;
                s2CarryReg <= s2CarryNext;
            end
            s2ValidReg <= ld2 | (s2ValidReg & ~OutReady);
        end
    end

    assign OutValid = s2ValidReg;
    assign ShOut    = s2DataReg;
    assign CarryOut = s2CarryReg;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter: a 32-bit RRX instance and a 16-bit no-RRX
// instance, checked against an arithmetic reference model.
module tb_pipelined_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        inValid32, inReady32, outValid32, outReady32, carryIn32, carryOut32;
    logic [31:0] shIn32, shOut32;
    logic [4:0]  shamt32;
    logic [1:0]  sh32;
    logic        inValid16, inReady16, outValid16, outReady16, carryIn16, carryOut16;
    logic [15:0] shIn16, shOut16;
    logic [3:0]  shamt16;
    logic [1:0]  sh16;

    int errors = 0;
    int checks = 0;

    pipelined_shifter #(.WIDTH(32), .RRX_EN(1'b1)) u32 (
        .CLK(clk), .Reset(reset), .InValid(inValid32), .InReady(inReady32),
        .ShIn(shIn32), .Shamt(shamt32), .Sh(sh32), .CarryIn(carryIn32),
        .OutValid(outValid32), .OutReady(outReady32), .ShOut(shOut32), .CarryOut(carryOut32)
    );

    pipelined_shifter #(.WIDTH(16), .RRX_EN(1'b0)) u16 (
        .CLK(clk), .Reset(reset), .InValid(inValid16), .InReady(inReady16),
        .ShIn(shIn16), .Shamt(shamt16), .Sh(sh16), .CarryIn(carryIn16),
        .OutValid(outValid16), .OutReady(outReady16), .ShOut(shOut16), .CarryOut(carryOut16)
    );

    // Reference: plain arithmetic on a 64-bit value, w = data width.
    function automatic void refShift(input int w, input bit rrx, input logic [31:0] d,
                                     input int n, input logic [1:0] sh, input bit cin,
                                     output logic [31:0] res, output bit c);
        longint unsigned mask, dv, r;
        mask = (64'd1 << w) - 64'd1;
        dv   = 64'(d) & mask;
        r    = dv;
        c    = cin;
        if (n == 0) begin
            if (sh == 2'd3 && rrx) begin
                r = (64'(cin) << (w - 1)) | (dv >> 1);
                c = dv[0];
            end
        end else begin
            case (sh)
                2'd0: begin r = (dv << n) & mask; c = dv[w - n]; end
                2'd1: begin r = dv >> n; c = dv[n - 1]; end
                2'd2: begin
                    r = dv >> n;
                    if (dv[w - 1]) r = r | (mask & ~(mask >> n));
                    c = dv[n - 1];
                end
                default: begin r = ((dv >> n) | (dv << (w - n))) & mask; c = dv[n - 1]; end
            endcase
        end
        res = 32'(r);
    endfunction

    // Drives one op into an empty 32-bit pipe; lat counts edges from presentation to OutValid.
    task automatic op32(input logic [31:0] d, input int n, input logic [1:0] sh, input bit cin,
                        output logic [31:0] res, output bit c, output int lat);
        shIn32 = d; shamt32 = 5'(n); sh32 = sh; carryIn32 = cin;
        inValid32 = 1'b1; outReady32 = 1'b1;
        lat = 0;
        @(posedge clk); #1;
        inValid32 = 1'b0;
        lat = 1;
        while (!outValid32 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        res = shOut32; c = carryOut32;
        $display("op32 d=%h n=%0d sh=%0d cin=%0d -> %h c=%0d lat=%0d", d, n, sh, cin, res, c, lat);
        @(posedge clk); #1;
    endtask

    task automatic op16(input logic [15:0] d, input int n, input logic [1:0] sh, input bit cin,
                        output logic [15:0] res, output bit c, output int lat);
        shIn16 = d; shamt16 = 4'(n); sh16 = sh; carryIn16 = cin;
        inValid16 = 1'b1; outReady16 = 1'b1;
        @(posedge clk); #1;
        inValid16 = 1'b0;
        lat = 1;
        while (!outValid16 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        res = shOut16; c = carryOut16;
        $display("op16 d=%h n=%0d sh=%0d cin=%0d -> %h c=%0d lat=%0d", d, n, sh, cin, res, c, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outValid32 !== 1'b0 || shOut32 !== 32'h0 || carryOut32 !== 1'b0 || inReady32 !== 1'b1) begin
            errors++;
            $display("FAIL reset32: valid=%b out=%h c=%b inReady=%b, want 0 0 0 1",
                     outValid32, shOut32, carryOut32, inReady32);
        end
        checks++;
        if (outValid16 !== 1'b0 || shOut16 !== 16'h0 || carryOut16 !== 1'b0 || inReady16 !== 1'b1) begin
            errors++;
            $display("FAIL reset16: valid=%b out=%h c=%b inReady=%b, want 0 0 0 1",
                     outValid16, shOut16, carryOut16, inReady16);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (inReady32 !== 1'b1 || outValid32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: inReady=%b valid=%b, want 1 0", inReady32, outValid32);
        end
    endtask

    task automatic test_directed32();
        logic [31:0] d[5]   = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_0003, 32'h0000_0001};
        int          n[5]   = '{1, 31, 31, 31, 0};
        logic [1:0]  sh[5]  = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        bit          ci[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] er[5]  = '{32'hC000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
        bit          ec[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] res;
        bit          c;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            op32(d[i], n[i], sh[i], ci[i], res, c, lat);
            checks++;
            if (res !== er[i] || c !== ec[i] || lat != 2) begin
                errors++;
                $display("FAIL directed32[%0d]: got %h c=%b lat=%0d, want %h c=%b lat=2",
                         i, res, c, lat, er[i], ec[i]);
            end
        end
    endtask

    task automatic test_directed16();
        logic [15:0] d[5]   = '{16'h8001, 16'h8000, 16'h8000, 16'h0003, 16'h0001};
        int          n[5]   = '{1, 15, 15, 15, 0};
        logic [1:0]  sh[5]  = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        bit          ci[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] er[5]  = '{16'hC000, 16'hFFFF, 16'h0001, 16'h8000, 16'h0001};
        bit          ec[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] res;
        bit          c;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            op16(d[i], n[i], sh[i], ci[i], res, c, lat);
            checks++;
            if (res !== er[i] || c !== ec[i] || lat != 2) begin
                errors++;
                $display("FAIL directed16[%0d]: got %h c=%b lat=%0d, want %h c=%b lat=2",
                         i, res, c, lat, er[i], ec[i]);
            end
        end
    endtask

    task automatic test_random_modes();
        logic [31:0] d, res, er;
        logic [15:0] res16;
        logic [1:0]  sh;
        bit          cin, c, ec;
        int          n, lat;
        for (int i = 0; i < 40; i++) begin
            d = $urandom; sh = 2'($urandom_range(0, 3)); cin = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31);
            refShift(32, 1'b1, d, n, sh, cin, er, ec);
            op32(d, n, sh, cin, res, c, lat);
            checks++;
            if (res !== er || c !== ec) begin
                errors++;
                $display("FAIL random32[%0d]: got %h c=%b, want %h c=%b", i, res, c, er, ec);
            end
            n = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
            refShift(16, 1'b0, d, n, sh, cin, er, ec);
            op16(d[15:0], n, sh, cin, res16, c, lat);
            checks++;
            if (res16 !== er[15:0] || c !== ec) begin
                errors++;
                $display("FAIL random16[%0d]: got %h c=%b, want %h c=%b", i, res16, c, er[15:0], ec);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expQ[$];
        bit          expCQ[$];
        logic [31:0] curD, er, prevOut;
        logic [1:0]  curSh;
        int          curN, sent, got, cyc;
        bit          curC, ec, needNew, prevStall, prevC;
        sent = 0; got = 0; cyc = 0; needNew = 1'b1; prevStall = 1'b0;
        prevOut = '0; prevC = 1'b0;
        curD = '0; curN = 0; curSh = '0; curC = 1'b0;
        while ((sent < 10 || got < 10) && cyc < 300) begin
            if (sent < 10 && needNew) begin
                curD = $urandom; curSh = 2'($urandom_range(0, 3));
                curN = $urandom_range(0, 31); curC = 1'($urandom_range(0, 1));
                needNew = 1'b0;
            end
            inValid32 = (sent < 10);
            shIn32 = curD; shamt32 = 5'(curN); sh32 = curSh; carryIn32 = curC;
            outReady32 = 1'($urandom_range(0, 1));
            #1;
            if (prevStall) begin
                checks++;
                if (outValid32 !== 1'b1 || shOut32 !== prevOut || carryOut32 !== prevC) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b out=%h c=%b, want 1 %h %b",
                             outValid32, shOut32, carryOut32, prevOut, prevC);
                end
            end
            if (outValid32 && outReady32) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got %h with nothing outstanding, want none", shOut32);
                end else begin
                    er = expQ.pop_front(); ec = expCQ.pop_front();
                    if (shOut32 !== er || carryOut32 !== ec) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got %h c=%b, want %h c=%b",
                                 got, shOut32, carryOut32, er, ec);
                    end
                end
                $display("b2b out[%0d] %h c=%b", got, shOut32, carryOut32);
                got++;
            end
            if (inValid32 && inReady32) begin
                refShift(32, 1'b1, curD, curN, curSh, curC, er, ec);
                expQ.push_back(er); expCQ.push_back(ec);
                sent++;
                needNew = 1'b1;
            end
            prevStall = outValid32 && !outReady32;
            prevOut = shOut32; prevC = carryOut32;
            @(posedge clk); #1;
            cyc++;
        end
        inValid32 = 1'b0; outReady32 = 1'b1;
        checks++;
        if (got != 10 || expQ.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d results with %0d left, want 10 and 0", got, expQ.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fill_stall();
        logic [31:0] d[3], er[3];
        bit          ec[3];
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            refShift(32, 1'b1, d[i], i + 3, 2'(i), 1'b0, er[i], ec[i]);
        end
        outReady32 = 1'b0; carryIn32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inValid32 = 1'b1; shIn32 = d[i]; shamt32 = 5'(i + 3); sh32 = 2'(i);
            #1;
            checks++;
            if (inReady32 !== (i < 2)) begin
                errors++;
                $display("FAIL fill_inready[%0d]: got %b, want %b", i, inReady32, (i < 2));
            end
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (inReady32 !== 1'b0 || outValid32 !== 1'b1 || shOut32 !== er[0]) begin
                errors++;
                $display("FAIL fill_hold: inReady=%b valid=%b out=%h, want 0 1 %h",
                         inReady32, outValid32, shOut32, er[0]);
            end
        end
        outReady32 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outValid32 !== 1'b1 || shOut32 !== er[i] || carryOut32 !== ec[i]) begin
                errors++;
                $display("FAIL drain[%0d]: valid=%b out=%h c=%b, want 1 %h %b",
                         i, outValid32, shOut32, carryOut32, er[i], ec[i]);
            end
            $display("drain out[%0d] %h c=%b", i, shOut32, carryOut32);
            @(posedge clk); #1;
            inValid32 = 1'b0;
        end
        checks++;
        if (outValid32 !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b, want 0", outValid32);
        end
    endtask

    task automatic test_reset_inflight();
        outReady32 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            inValid32 = 1'b1; shIn32 = 32'hA5A5_0001 + 32'(i); shamt32 = 5'd0;
            sh32 = 2'd3; carryIn32 = 1'b1;
            @(posedge clk); #1;
        end
        inValid32 = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (outValid32 !== 1'b0 || shOut32 !== 32'h0 || carryOut32 !== 1'b0 || inReady32 !== 1'b1) begin
            errors++;
            $display("FAIL reset_inflight: valid=%b out=%h c=%b inReady=%b, want 0 0 0 1",
                     outValid32, shOut32, carryOut32, inReady32);
        end
        outReady32 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (outValid32 !== 1'b0) begin
                errors++;
                $display("FAIL stale_output[%0d]: valid=%b out=%h, want valid 0", i, outValid32, shOut32);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inValid32 = 1'b0; outReady32 = 1'b1; shIn32 = '0; shamt32 = '0; sh32 = '0; carryIn32 = 1'b0;
        inValid16 = 1'b0; outReady16 = 1'b1; shIn16 = '0; shamt16 = '0; sh16 = '0; carryIn16 = 1'b0;
        test_reset();
        test_directed32();
        test_directed16();
        test_random_modes();
        test_back_to_back();
        test_fill_stall();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
